// File: rtl/axi_gpio_if.sv
// axi_gpio_if: AXI4-Lite bus bundle between interconnect master and GPIO slave
interface axi_gpio_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_gpio.sv
// axi_gpio: AXI4-Lite slave with an LED register and synchronised switch/button inputs
module axi_gpio #(
    parameter int LED_W = 8,
    parameter int SW_W  = 8,
    parameter int BTN_W = 5
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    axi_gpio_if.slave        s,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  switch,
    input  logic [BTN_W-1:0] button
);
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    wstate_t          wstate_q, wstate_d;
    rstate_t          rstate_q, rstate_d;
    logic [LED_W-1:0] led_q;
    logic [1:0]       bresp_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
    logic             wr_led;
    logic             unused;
    assign unused = ^{s.AWADDR, s.ARADDR, s.AWPROT, s.ARPROT, s.WDATA, s.WSTRB};
    assign led       = led_q;
    assign s.AWREADY = wstate_q == W_ACK;
    assign s.WREADY  = wstate_q == W_ACK;
    assign s.BVALID  = wstate_q == W_RESP;
    assign s.BRESP   = bresp_q;
    assign s.ARREADY = rstate_q == R_IDLE;
    assign s.RVALID  = rstate_q == R_DATA;
    assign s.RDATA   = rdata_q;
    assign s.RRESP   = rresp_q;
    assign wr_led    = s.AWADDR[3:2] == 2'd0;
    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            sw_s1_q  <= switch;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
        end
    end
    // Write engine next state: wait for both address and data, ack once, then hold response
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  wstate_d = (s.AWVALID && s.WVALID) ? W_ACK : W_IDLE;
            W_ACK:   wstate_d = W_RESP;
            W_RESP:  wstate_d = s.BREADY ? W_IDLE : W_RESP;
            default: wstate_d = W_IDLE;
        endcase
    end
    // Write engine state, LED register and response capture at the end of the ack cycle
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            wstate_q <= W_IDLE;
            led_q    <= '0;
            bresp_q  <= 2'b00;
        end else begin
            wstate_q <= wstate_d;
            if (wstate_q == W_ACK) begin
                bresp_q <= wr_led ? 2'b00 : 2'b10;
                if (wr_led && s.WSTRB[0]) led_q <= s.WDATA[LED_W-1:0];
            end
        end
    end
    // Read engine next state and decoded read data for the address handshake edge
    always_comb begin
        rstate_d = (rstate_q == R_IDLE) ? (s.ARVALID ? R_DATA : R_IDLE)
                                        : (s.RREADY ? R_IDLE : R_DATA);
        rdata_d  = (s.ARADDR[3:2] == 2'd0) ? 32'(led_q) :
                   (s.ARADDR[3:2] == 2'd1) ? 32'(sw_s2_q) :
                   (s.ARADDR[3:2] == 2'd2) ? 32'(btn_s2_q) : 32'd0;
        rresp_d  = (s.ARADDR[3:2] == 2'd3) ? 2'b10 : 2'b00;
    end
    // Read engine state; data and response frozen while the beat is outstanding
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else begin
            rstate_q <= rstate_d;
            if (rstate_q == R_IDLE && s.ARVALID) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end
endmodule

// File: tb/tb_axi_gpio.sv
// tb_axi_gpio: scoreboard-based self-checking bench for axi_gpio
module tb_axi_gpio;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led;
    logic [7:0] sw_r = 8'h55;
    logic [4:0] btn_r = 5'h07;
    logic [7:0] led_m = 8'h00;
    logic [33:0] rq[$];
    logic [1:0]  wq[$];
    int total = 0;
    int bad = 0;
    axi_gpio_if bus();
    axi_gpio dut (
        .ACLK(clk),
        .ARESETn(rst),
        .s(bus.slave),
        .led(led),
        .switch(sw_r),
        .button(btn_r)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_read(input logic [31:0] addr, input int stall);
        logic [33:0] exp;
        logic [31:0] d0;
        case (addr[3:2])
            2'd0: rq.push_back({32'(led_m), 2'b00});
            2'd1: rq.push_back({32'(sw_r), 2'b00});
            2'd2: rq.push_back({32'(btn_r), 2'b00});
            default: rq.push_back({32'd0, 2'b10});
        endcase
        bus.ARADDR = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY = (stall == 0);
        total++;
        if (bus.ARREADY !== 1'b1) begin bad++; $display("FAIL arready_idle addr=%h got=%b exp=1", addr, bus.ARREADY); end
        tick;
        bus.ARVALID = 1'b0;
        total++;
        if (bus.RVALID !== 1'b1 || bus.ARREADY !== 1'b0) begin
            bad++; $display("FAIL rvalid_rise addr=%h got rvalid=%b arready=%b exp 1/0", addr, bus.RVALID, bus.ARREADY);
        end
        d0 = bus.RDATA;
        for (int i = 0; i < stall; i++) begin
            tick;
            total++;
            if (bus.RVALID !== 1'b1 || bus.RDATA !== d0) begin
                bad++; $display("FAIL r_hold addr=%h got rvalid=%b rdata=%h exp 1/%h", addr, bus.RVALID, bus.RDATA, d0);
            end
        end
        bus.RREADY = 1'b1;
        total++;
        if (rq.size() == 0) begin
            bad++; $display("FAIL r_scoreboard_empty addr=%h got=%h exp=none", addr, bus.RDATA);
        end else begin
            exp = rq.pop_front();
            if ({bus.RDATA, bus.RRESP} !== exp) begin
                bad++; $display("FAIL rdata addr=%h got=%h/%b exp=%h/%b", addr, bus.RDATA, bus.RRESP, exp[33:2], exp[1:0]);
            end
        end
        tick;
        bus.RREADY = 1'b0;
        total++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
            bad++; $display("FAIL r_done addr=%h got rvalid=%b arready=%b exp 0/1", addr, bus.RVALID, bus.ARREADY);
        end
    endtask
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit lead, input int stall);
        logic [1:0] er;
        int n;
        wq.push_back((addr[3:2] == 2'd0) ? 2'b00 : 2'b10);
        if (addr[3:2] == 2'd0 && strb[0]) led_m = data[7:0];
        bus.AWADDR = addr;
        bus.WDATA = data;
        bus.WSTRB = strb;
        bus.AWVALID = 1'b1;
        if (lead) begin
            tick;
            total++;
            if (bus.AWREADY !== 1'b0) begin bad++; $display("FAIL aw_alone got=%b exp=0", bus.AWREADY); end
        end
        bus.WVALID = 1'b1;
        n = 0;
        while (bus.AWREADY !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        total++;
        if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
            bad++; $display("FAIL aw_ack addr=%h got aw=%b w=%b exp 1/1", addr, bus.AWREADY, bus.WREADY);
        end
        tick;
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b0;
        total++;
        if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0 || bus.BVALID !== 1'b1) begin
            bad++; $display("FAIL w_pulse addr=%h got aw=%b w=%b bvalid=%b exp 0/0/1", addr, bus.AWREADY, bus.WREADY, bus.BVALID);
        end
        total++;
        if (led !== led_m) begin bad++; $display("FAIL led addr=%h got=%h exp=%h", addr, led, led_m); end
        for (int i = 0; i < stall; i++) begin
            tick;
            total++;
            if (bus.BVALID !== 1'b1) begin bad++; $display("FAIL b_hold addr=%h got=%b exp=1", addr, bus.BVALID); end
        end
        bus.BREADY = 1'b1;
        total++;
        if (wq.size() == 0) begin
            bad++; $display("FAIL b_scoreboard_empty addr=%h got=%b exp=none", addr, bus.BRESP);
        end else begin
            er = wq.pop_front();
            if (bus.BRESP !== er) begin bad++; $display("FAIL bresp addr=%h got=%b exp=%b", addr, bus.BRESP, er); end
        end
        tick;
        bus.BREADY = 1'b0;
        total++;
        if (bus.BVALID !== 1'b0) begin bad++; $display("FAIL b_done addr=%h got=%b exp=0", addr, bus.BVALID); end
    endtask
    task automatic test_reset;
        tick;
        tick;
        total++;
        if (led !== 8'h00 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0 || bus.BVALID !== 1'b0 || bus.BRESP !== 2'b00) begin
            bad++; $display("FAIL reset_wr got led=%h aw=%b w=%b bv=%b br=%b exp 00/0/0/0/00", led, bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP);
        end
        total++;
        if (bus.RVALID !== 1'b0 || bus.RDATA !== 32'h0 || bus.RRESP !== 2'b00 || bus.ARREADY !== 1'b1) begin
            bad++; $display("FAIL reset_rd got rv=%b rd=%h rr=%b ar=%b exp 0/0/00/1", bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY);
        end
        rst = 1'b0;
        tick;
        tick;
        tick;
    endtask
    task automatic test_read_inputs;
        do_read(32'h4, 0);
        do_read(32'h8, 5);
    endtask
    task automatic test_write_led;
        do_write(32'h0, 32'hFF, 4'h1, 1'b1, 3);
        do_write(32'h0, 32'hAA, 4'h1, 1'b1, 0);
        do_read(32'h0, 0);
    endtask
    task automatic test_unmapped;
        do_read(32'hC, 2);
    endtask
    task automatic test_write_misc;
        do_write(32'h1, 32'h0A, 4'h1, 1'b0, 0);
        do_write(32'h4, 32'hFF, 4'h1, 1'b0, 2);
        do_write(32'h0, 32'h55, 4'hE, 1'b0, 1);
        do_write(32'hC, 32'h77, 4'hF, 1'b1, 0);
        do_read(32'h0, 1);
    endtask
    task automatic test_back_to_back;
        sw_r = 8'hA3;
        btn_r = 5'h1C;
        tick;
        tick;
        tick;
        do_read(32'h14, 0);
        do_read(32'hFFFF_FFFB, 0);
        do_write(32'h0, 32'h1234_5681, 4'h1, 1'b0, 0);
        do_read(32'h3, 0);
    endtask
    task automatic test_reset_mid;
        bus.AWADDR = 32'h0;
        bus.WDATA = 32'h33;
        bus.WSTRB = 4'h1;
        bus.AWVALID = 1'b1;
        bus.WVALID = 1'b1;
        tick;
        tick;
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b0;
        bus.ARADDR = 32'h4;
        bus.ARVALID = 1'b1;
        tick;
        bus.ARVALID = 1'b0;
        total++;
        if (bus.BVALID !== 1'b1 || bus.RVALID !== 1'b1 || led !== 8'h33) begin
            bad++; $display("FAIL mid_setup got bv=%b rv=%b led=%h exp 1/1/33", bus.BVALID, bus.RVALID, led);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0 || led !== 8'h00 || bus.ARREADY !== 1'b1) begin
            bad++; $display("FAIL mid_reset got bv=%b rv=%b led=%h ar=%b exp 0/0/00/1", bus.BVALID, bus.RVALID, led, bus.ARREADY);
        end
        led_m = 8'h00;
        tick;
        rst = 1'b0;
        tick;
        tick;
        tick;
        total++;
        if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0) begin
            bad++; $display("FAIL post_reset got bv=%b rv=%b exp 0/0", bus.BVALID, bus.RVALID);
        end
        do_read(32'h0, 0);
    endtask
    initial begin
        bus.AWVALID = 1'b0;
        bus.AWADDR = '0;
        bus.AWPROT = '0;
        bus.WVALID = 1'b0;
        bus.WDATA = '0;
        bus.WSTRB = '0;
        bus.BREADY = 1'b0;
        bus.ARVALID = 1'b0;
        bus.ARADDR = '0;
        bus.ARPROT = '0;
        bus.RREADY = 1'b0;
        test_reset;
        test_read_inputs;
        test_write_led;
        test_unmapped;
        test_write_misc;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_gpio.md
Name: axi_gpio

Overview:
AXI4-Lite slave exposing board GPIO to the PS/interconnect: one read/write LED output register and two read-only input registers (switches, buttons). Single-beat, non-pipelined transactions, one read and one write engine operating independently. Sits between the AXI GP port and board pins.

Parameters:
LED_W, 8, width of led output register
SW_W, 8, width of switch input
BTN_W, 5, width of button input

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous reset, active-high (despite name)
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  32  write address
AWPROT  in  3  ignored
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response (00 OKAY, 10 SLVERR)
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  32  read address
ARPROT  in  3  ignored
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  32  read data
RRESP  out  2  read response
led  out  LED_W  LED register contents
switch  in  SW_W  switch pins (asynchronous)
button  in  BTN_W  button pins (asynchronous)

Behaviour:
- Reset (ARESETn=1, async): led=0, AWREADY=WREADY=0, BVALID=0, BRESP=00, RVALID=0, RDATA=0, RRESP=00, both FSMs to IDLE; ARREADY=1 (combinational from IDLE state).
- Register map, decode ADDR[3:2], ADDR[1:0] and ADDR[31:4] ignored: 0x0 LED (RW, bits[LED_W-1:0]); 0x4 SWITCH (RO); 0x8 BUTTON (RO); 0xC unmapped.
- switch/button pass through 2-flop synchronisers (reset 0) before readout; read value = synchronised value, zero-extended to 32 bits.
- Write FSM: IDLE -> ACK when AWVALID&&WVALID both high at a rising edge (either alone: wait in IDLE). ACK: AWREADY=WREADY=1 for exactly one cycle; at end of that cycle address/data captured and register updated; -> RESP. RESP: BVALID=1, BRESP held stable until BVALID&&BREADY at an edge, then -> IDLE (BVALID=0 next cycle). Minimum 3 cycles per write.
- Write to 0x0: if WSTRB[0]=1 led<=WDATA[LED_W-1:0], BRESP=OKAY; if WSTRB[0]=0 no update, BRESP=OKAY.
- Write to 0x4/0x8/0xC: no state change, BRESP=SLVERR.
- Read FSM: IDLE (ARREADY=1) -> DATA on rising edge with ARVALID=1; at that edge RDATA/RRESP loaded from decoded register. DATA: ARREADY=0, RVALID=1, RDATA/RRESP stable until RVALID&&RREADY at an edge, then -> IDLE (RVALID=0, ARREADY=1 next cycle). RREADY held high beforehand completes in one DATA cycle.
- Read 0x0/0x4/0x8: RRESP=OKAY. Read 0xC: RDATA=0, RRESP=SLVERR.
- Read and write engines independent; simultaneous read of 0x0 and write to 0x0: read returns pre-write value if its address handshake edge precedes or coincides with the write-capture edge.
- Reset mid-transaction aborts immediately; no response issued after reset.

Test Plan:
- switch=0x55, button=0x07; read 0x4 with RREADY=1 -> ARREADY high at handshake, RVALID one cycle later, RDATA=0x00000055, RRESP=00.
- Read 0x8, RREADY held low 4+ cycles -> RVALID and RDATA=0x00000007 held stable until RREADY, then RVALID drops next edge.
- Write 0xFF to 0x0 (AWVALID one cycle before WVALID, WSTRB=1) -> AWREADY/WREADY single-cycle pulse, led=0xFF, BVALID held until BREADY, BRESP=00; repeat with 0xAA -> led=0xAA; read 0x0 -> RDATA=0xAA.
- Read 0xC -> RDATA=0, RRESP=10.
- Write 0x0A to address 0x1 -> led=0x0A, OKAY; write 0xFF to 0x4 -> BRESP=10, led stays 0x0A.
- Assert reset during RESP/DATA states -> BVALID/RVALID=0, led=0, ARREADY=1 immediately.
